fork_join_sched: RTL and testbench

//  Hardware fork/join scheduler. One start launches a group of N worker engines in parallel.

---
 rtl/fork_join_sched.sv | 159 +++++++++++++++
 tb/tb_fork_join_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_join_sched.sv
// Fork/join scheduler: launches a group of worker engines on one start and
// reports completion as JOIN_ALL, JOIN_ANY or JOIN_NONE, with kill (disable fork).
module fork_join_sched #(
    parameter int unsigned N_WORKERS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [N_WORKERS-1:0] enable_mask,
    input  logic                 kill,
    input  logic [N_WORKERS-1:0] worker_done,
    output logic [N_WORKERS-1:0] worker_go,
    output logic [N_WORKERS-1:0] worker_abort,
    output logic                 busy,
    output logic                 join_done,
    output logic [((N_WORKERS > 1) ? $clog2(N_WORKERS) : 1)-1:0] first_id,
    output logic [N_WORKERS-1:0] outstanding,
    output logic                 all_idle,
    output logic                 start_err
);

    localparam int unsigned IDW = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;

    localparam logic [1:0] MODE_ALL  = 2'b00;
    localparam logic [1:0] MODE_ANY  = 2'b01;
    localparam logic [1:0] MODE_NONE = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [N_WORKERS-1:0] r_grp;
    logic                 r_join_any;
    logic [N_WORKERS-1:0] r_worker_go;
    logic [N_WORKERS-1:0] r_worker_abort;
    logic                 r_busy;
    logic                 r_join_done;
    logic [IDW-1:0]       r_first_id;
    logic [N_WORKERS-1:0] r_outstanding;
    logic                 r_all_idle;
    logic                 r_start_err;

    logic [N_WORKERS-1:0] w_done_cnt;
    logic [N_WORKERS-1:0] w_any_hit;
    logic [IDW-1:0]       w_any_id;
    logic                 w_start_legal;
    logic                 w_accept;
    logic [N_WORKERS-1:0] w_out_next;

    // Done pulses only count for workers still outstanding; overlap is checked
    // against the current outstanding set, before this cycle's dones retire.
    always_comb begin
        w_done_cnt    = worker_done & r_outstanding;
        w_any_hit     = w_done_cnt & r_grp;
        w_start_legal = (mode != MODE_RSVD) && (|enable_mask)
                        && ((enable_mask & r_outstanding) == '0);
        w_accept      = (r_state == S_IDLE) && start && w_start_legal;
        w_out_next    = (r_outstanding & ~w_done_cnt)
                        | (w_accept ? enable_mask : '0);
    end

    // Lowest index among simultaneous JOIN_ANY completions.
    always_comb begin
        w_any_id = '0;
        for (int i = N_WORKERS - 1; i >= 0; i--) begin
            if (w_any_hit[i]) begin
                w_any_id = IDW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_grp          <= '0;
            r_join_any     <= 1'b0;
            r_worker_go    <= '0;
            r_worker_abort <= '0;
            r_busy         <= 1'b0;
            r_join_done    <= 1'b0;
            r_first_id     <= '0;
            r_outstanding  <= '0;
            r_all_idle     <= 1'b1;
            r_start_err    <= 1'b0;
        end else begin
            r_worker_go    <= '0;
            r_worker_abort <= '0;
            r_join_done    <= 1'b0;
            r_start_err    <= 1'b0;
            if (kill) begin
                // Disable fork overrides any start or done in the same cycle.
                r_worker_abort <= r_outstanding;
                r_outstanding  <= '0;
                r_all_idle     <= 1'b1;
                r_grp          <= '0;
                r_state        <= S_IDLE;
                r_busy         <= 1'b0;
            end else begin
                r_outstanding <= w_out_next;
                r_all_idle    <= (w_out_next == '0);
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_start_legal) begin
                                r_worker_go <= enable_mask;
                                r_grp       <= enable_mask;
                                r_join_any  <= (mode == MODE_ANY);
                                if (mode == MODE_NONE) begin
                                    r_join_done <= 1'b1;
                                end else begin
                                    r_state <= S_RUN;
                                    r_busy  <= 1'b1;
                                end
                            end else begin
                                r_start_err <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (r_join_any) begin
                            if (|w_any_hit) begin
                                r_join_done <= 1'b1;
                                r_first_id  <= w_any_id;
                                r_state     <= S_IDLE;
                                r_busy      <= 1'b0;
                            end
                        end else if ((r_grp & w_out_next) == '0) begin
                            r_join_done <= 1'b1;
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // MODE_ALL documents the default join behaviour taken in S_RUN.
    logic w_unused_mode_all;
    assign w_unused_mode_all = (MODE_ALL == 2'b00);

    assign worker_go    = r_worker_go;
    assign worker_abort = r_worker_abort;
    assign busy         = r_busy;
    assign join_done    = r_join_done;
    assign first_id     = r_first_id;
    assign outstanding  = r_outstanding;
    assign all_idle     = r_all_idle;
    assign start_err    = r_start_err;

endmodule

// File: tb/tb_fork_join_sched.sv
// Directed testbench for fork_join_sched: each output compared against
// hand-computed values one edge after the stimulus cycle.
module tb_fork_join_sched;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [3:0] enable_mask;
    logic       kill;
    logic [3:0] worker_done;
    logic [3:0] worker_go;
    logic [3:0] worker_abort;
    logic       busy;
    logic       join_done;
    logic [1:0] first_id;
    logic [3:0] outstanding;
    logic       all_idle;
    logic       start_err;

    int unsigned n_cmp;
    int unsigned n_err;

    fork_join_sched #(.N_WORKERS(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .enable_mask  (enable_mask),
        .kill         (kill),
        .worker_done  (worker_done),
        .worker_go    (worker_go),
        .worker_abort (worker_abort),
        .busy         (busy),
        .join_done    (join_done),
        .first_id     (first_id),
        .outstanding  (outstanding),
        .all_idle     (all_idle),
        .start_err    (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then stable for sampling and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        kill        = 1'b0;
        worker_done = 4'b0000;
    endtask

    task automatic launch(input logic [1:0] m, input logic [3:0] msk);
        start       = 1'b1;
        mode        = m;
        enable_mask = msk;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        mode = 2'b00;
        enable_mask = 4'b0000;
        idle_inputs();
        tick();
        tick();
        check("rst_go",       32'(worker_go), 'h0);
        check("rst_abort",    32'(worker_abort), 'h0);
        check("rst_busy",     32'(busy), 'h0);
        check("rst_join",     32'(join_done), 'h0);
        check("rst_first",    32'(first_id), 'h0);
        check("rst_outst",    32'(outstanding), 'h0);
        check("rst_all_idle", 32'(all_idle), 'h1);
        check("rst_err",      32'(start_err), 'h0);
        rst_n = 1'b1;
        tick();

        // T1 JOIN_ALL 1011: dones at +3, +5, +8, join only at +9
        launch(2'b00, 4'b1011);
        check("t1_go",    32'(worker_go), 'hB);
        check("t1_out1",  32'(outstanding), 'hB);
        check("t1_busy",  32'(busy), 'h1);
        tick();
        check("t1_go_clr", 32'(worker_go), 'h0);
        tick();
        worker_done = 4'b0001;
        tick();
        worker_done = 4'b0000;
        check("t1_out2",  32'(outstanding), 'hA);
        check("t1_nj4",   32'(join_done), 'h0);
        tick();
        worker_done = 4'b1000;
        tick();
        worker_done = 4'b0000;
        check("t1_out3",  32'(outstanding), 'h2);
        check("t1_nj6",   32'(join_done), 'h0);
        tick();
        check("t1_nj7",   32'(join_done), 'h0);
        tick();
        worker_done = 4'b0010;
        tick();
        worker_done = 4'b0000;
        check("t1_join",  32'(join_done), 'h1);
        check("t1_out4",  32'(outstanding), 'h0);
        check("t1_busy0", 32'(busy), 'h0);
        check("t1_idle",  32'(all_idle), 'h1);
        tick();
        check("t1_jpulse", 32'(join_done), 'h0);

        // T2 JOIN_ANY 0110: simultaneous dones pick lowest index
        launch(2'b01, 4'b0110);
        check("t2_go",    32'(worker_go), 'h6);
        worker_done = 4'b0110;
        tick();
        worker_done = 4'b0000;
        check("t2_join",  32'(join_done), 'h1);
        check("t2_first", 32'(first_id), 'h1);
        check("t2_out",   32'(outstanding), 'h0);
        check("t2_busy",  32'(busy), 'h0);
        launch(2'b01, 4'b0110);
        worker_done = 4'b0100;
        tick();
        worker_done = 4'b0000;
        check("t2b_join",  32'(join_done), 'h1);
        check("t2b_first", 32'(first_id), 'h2);
        check("t2b_out",   32'(outstanding), 'h2);
        // leftover done in IDLE retires only
        worker_done = 4'b0010;
        tick();
        worker_done = 4'b0000;
        check("t2c_out",   32'(outstanding), 'h0);
        check("t2c_nj",    32'(join_done), 'h0);
        check("t2c_first", 32'(first_id), 'h2);

        // T3 JOIN_NONE 1111, then overlapping start rejected
        launch(2'b10, 4'b1111);
        check("t3_go",   32'(worker_go), 'hF);
        check("t3_join", 32'(join_done), 'h1);
        check("t3_busy", 32'(busy), 'h0);
        launch(2'b10, 4'b0001);
        check("t3_err",  32'(start_err), 'h1);
        check("t3_nogo", 32'(worker_go), 'h0);
        check("t3_out",  32'(outstanding), 'hF);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("t3_abort", 32'(worker_abort), 'hF);
        check("t3_idle",  32'(all_idle), 'h1);

        // T4 JOIN_ALL 1111 killed two cycles after go
        launch(2'b00, 4'b1111);
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("t4_abort", 32'(worker_abort), 'hF);
        check("t4_idle",  32'(all_idle), 'h1);
        check("t4_nj",    32'(join_done), 'h0);
        check("t4_busy",  32'(busy), 'h0);
        tick();
        check("t4_apulse", 32'(worker_abort), 'h0);
        launch(2'b00, 4'b1111);
        kill = 1'b1;
        worker_done = 4'b0001;
        tick();
        idle_inputs();
        check("t4b_abort", 32'(worker_abort), 'hF);
        check("t4b_nj",    32'(join_done), 'h0);
        check("t4b_out",   32'(outstanding), 'h0);

        // T5 rejected starts, stray done, start during RUN, kill+start
        launch(2'b11, 4'b0001);
        check("t5_rsvd_err", 32'(start_err), 'h1);
        check("t5_rsvd_go",  32'(worker_go), 'h0);
        check("t5_rsvd_bsy", 32'(busy), 'h0);
        launch(2'b00, 4'b0000);
        check("t5_zero_err", 32'(start_err), 'h1);
        worker_done = 4'b1000;
        tick();
        worker_done = 4'b0000;
        check("t5_stray_out", 32'(outstanding), 'h0);
        check("t5_stray_nj",  32'(join_done), 'h0);
        check("t5_stray_idl", 32'(all_idle), 'h1);
        kill = 1'b1;
        launch(2'b00, 4'b0010);
        kill = 1'b0;
        check("t5_ks_go",  32'(worker_go), 'h0);
        check("t5_ks_err", 32'(start_err), 'h0);
        check("t5_ks_out", 32'(outstanding), 'h0);
        launch(2'b00, 4'b0001);
        check("t5_run_busy", 32'(busy), 'h1);
        launch(2'b00, 4'b0010);
        check("t5_run_go",  32'(worker_go), 'h0);
        check("t5_run_err", 32'(start_err), 'h0);
        check("t5_run_out", 32'(outstanding), 'h1);
        worker_done = 4'b0001;
        tick();
        worker_done = 4'b0000;
        check("t5_run_join", 32'(join_done), 'h1);

        // T6 reset during RUN clears everything without abort
        launch(2'b00, 4'b0101);
        check("t6_out", 32'(outstanding), 'h5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_abort", 32'(worker_abort), 'h0);
        check("t6_out0",  32'(outstanding), 'h0);
        check("t6_busy",  32'(busy), 'h0);
        check("t6_idle",  32'(all_idle), 'h1);
        check("t6_first", 32'(first_id), 'h0);
        launch(2'b01, 4'b0001);
        check("t6_go", 32'(worker_go), 'h1);
        worker_done = 4'b0001;
        tick();
        worker_done = 4'b0000;
        check("t6_join",  32'(join_done), 'h1);
        check("t6_first2", 32'(first_id), 'h0);
        check("t6_out1",  32'(outstanding), 'h0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
